// File: rtl/wb_writer_pkg.sv
// wb_writer_pkg: shared widths and the {rd, data} write-beat record
package wb_writer_pkg;
    localparam int XLEN   = 32;
    localparam int REG_AW = 5;
    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic [XLEN-1:0]   data;
    } wb_entry_t;
endpackage

// File: rtl/wb_writer_fifo.sv
// wb_fifo: synchronous queue of write entries with per-entry rd match vectors
// Ports: clk/rst; push/din enqueue; pop dequeues head; count/full/empty status;
//        rs1_match/rs2_match flag live entries whose rd equals rs1_addr/rs2_addr.
module wb_fifo
    import wb_writer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      push,
    input  logic                      pop,
    input  wb_entry_t                 din,
    input  logic [REG_AW-1:0]         rs1_addr,
    input  logic [REG_AW-1:0]         rs2_addr,
    output wb_entry_t                 head,
    output logic [$clog2(DEPTH):0]    count,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0]          rs1_match,
    output logic [DEPTH-1:0]          rs2_match
);
    localparam int AW = $clog2(DEPTH);
    wb_entry_t mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   count_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            if (push) wr_q <= wr_q + 1'b1;
            if (pop) rd_q <= rd_q + 1'b1;
            count_q <= count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        end
    end
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= din;
    end
    assign head  = mem_q[rd_q];
    assign count = count_q;
    assign full  = count_q == (AW+1)'(DEPTH);
    assign empty = count_q == '0;
    // An entry is live when its distance from the read pointer is below count.
    for (genvar i = 0; i < DEPTH; i++) begin : g_match
        logic [AW-1:0] off;
        logic          live;
        assign off          = AW'(i) - rd_q;
        assign live         = {1'b0, off} < count_q;
        assign rs1_match[i] = live && mem_q[i].rd == rs1_addr;
        assign rs2_match[i] = live && mem_q[i].rd == rs2_addr;
    end
endmodule

// File: rtl/wb_writer.sv
// wb_writer: arbitrates ALU and LSU results onto the single regfile write port
// Ports: clk/rst; alu_valid/ready/rd/data and lsu_valid/ready/rd/data result
//        handshakes; issue_load/issue_rd mark pending loads; rs1/rs2_addr in,
//        rs1/rs2_busy out for issue stalls; reg_wr_en/rd_addr/w_data registered beat.
module wb_writer
    import wb_writer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [REG_AW-1:0] alu_rd,
    input  logic [XLEN-1:0]   alu_data,
    input  logic              lsu_valid,
    output logic              lsu_ready,
    input  logic [REG_AW-1:0] lsu_rd,
    input  logic [XLEN-1:0]   lsu_data,
    input  logic              issue_load,
    input  logic [REG_AW-1:0] issue_rd,
    input  logic [REG_AW-1:0] rs1_addr,
    input  logic [REG_AW-1:0] rs2_addr,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              reg_wr_en,
    output logic [REG_AW-1:0] rd_addr,
    output logic [XLEN-1:0]   w_data
);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam int NR = 1 << REG_AW;
    wb_entry_t head, beat_d, beat_q;
    logic [$clog2(FIFO_DEPTH):0] count;
    logic full, empty, lsu_fire, alu_fire, pop, bypass, push, beat_v, hold, en_q;
    logic [FIFO_DEPTH-1:0] rs1_match, rs2_match;
    logic [SW-1:0] starve_q, starve_d;
    logic [NR-1:0] busy_q, busy_d;
    wb_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (pop),
        .din       ('{rd: alu_rd, data: alu_data}),
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .head      (head),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .rs1_match (rs1_match),
        .rs2_match (rs2_match)
    );
    // After STARVE_MAX back-to-back LSU wins over a waiting queue, the LSU sits out one cycle.
    assign hold      = starve_q == SW'(STARVE_MAX);
    assign lsu_ready = !rst && !hold;
    assign alu_ready = !rst && !full;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign alu_fire  = alu_valid && alu_ready;
    assign pop       = !lsu_fire && !empty;
    assign bypass    = alu_fire && !lsu_fire && empty;
    assign push      = alu_fire && !bypass;
    assign beat_v    = lsu_fire || pop || bypass;
    assign beat_d    = lsu_fire ? '{rd: lsu_rd, data: lsu_data} : pop ? head : '{rd: alu_rd, data: alu_data};
    assign starve_d  = (pop || count == '0) ? '0 : lsu_fire ? starve_q + 1'b1 : starve_q;
    always_comb begin
        busy_d = busy_q;
        if (lsu_fire) busy_d[lsu_rd] = 1'b0;
        if (issue_load) busy_d[issue_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end
    // The beat register is not searched: the regfile commits it before decode reads.
    assign rs1_busy  = |rs1_addr && (busy_q[rs1_addr] || |rs1_match);
    assign rs2_busy  = |rs2_addr && (busy_q[rs2_addr] || |rs2_match);
    assign reg_wr_en = en_q;
    assign rd_addr   = beat_q.rd;
    assign w_data    = beat_q.data;
    always_ff @(posedge clk) begin
        if (rst) begin
            en_q     <= 1'b0;
            beat_q   <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            en_q     <= beat_v && |beat_d.rd;
            if (beat_v && |beat_d.rd) beat_q <= beat_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end
endmodule

// File: tb/tb_wb_writer.sv
// tb_wb_writer: directed stimulus with a queue-based reference model of the write port
module tb_wb_writer;
    import wb_writer_pkg::*;
    localparam int DEPTH = 4;
    localparam int SMAX  = 4;
    logic clk = 0, rst = 1;
    logic alu_valid = 0, lsu_valid = 0, issue_load = 0;
    logic [4:0] alu_rd = 0, lsu_rd = 0, issue_rd = 0, rs1_addr = 0, rs2_addr = 0;
    logic [31:0] alu_data = 0, lsu_data = 0;
    logic alu_ready, lsu_ready, rs1_busy, rs2_busy, reg_wr_en;
    logic [4:0] rd_addr;
    logic [31:0] w_data;
    int checks = 0, failures = 0;
    wb_writer #(.FIFO_DEPTH(DEPTH), .STARVE_MAX(SMAX)) dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
        .issue_load(issue_load), .issue_rd(issue_rd),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
        .reg_wr_en(reg_wr_en), .rd_addr(rd_addr), .w_data(w_data)
    );
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: an in-order ALU queue, a pending-load set and a count of
    // consecutive LSU wins while ALU results wait.
    wb_entry_t q[$];
    wb_entry_t b;
    bit [31:0] busy = '0;
    int starve = 0;
    bit started = 0, has, m_lf, m_af, m_en, popped;
    logic [4:0] m_rd = 0;
    logic [31:0] m_data = 0;
    int n0;

    function automatic bit mbusy(input logic [4:0] a);
        if (a == 0) return 0;
        if (busy[a]) return 1;
        foreach (q[i]) if (q[i].rd == a) return 1;
        return 0;
    endfunction

    always @(posedge clk) begin
        started = 1;
        if (rst) begin
            q.delete();
            busy = '0; starve = 0; m_en = 0; m_rd = 0; m_data = 0; m_lf = 0; m_af = 0;
        end else begin
            n0 = q.size();
            m_lf = lsu_valid && starve < SMAX;
            m_af = alu_valid && q.size() < DEPTH;
            has = 0; popped = 0;
            if (m_lf) begin
                b = '{rd: lsu_rd, data: lsu_data}; has = 1;
                if (m_af) q.push_back('{rd: alu_rd, data: alu_data});
            end else if (q.size() > 0) begin
                b = q.pop_front(); has = 1; popped = 1;
                if (m_af) q.push_back('{rd: alu_rd, data: alu_data});
            end else if (m_af) begin
                b = '{rd: alu_rd, data: alu_data}; has = 1;
            end
            if (popped || n0 == 0) starve = 0;
            else if (m_lf) starve++;
            if (m_lf) busy[lsu_rd] = 0;
            if (issue_load && issue_rd != 0) busy[issue_rd] = 1;
            m_en = has && b.rd != 0;
            if (m_en) begin m_rd = b.rd; m_data = b.data; end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("alu_ready", 32'(alu_ready), 32'(!rst && q.size() < DEPTH));
            chk("lsu_ready", 32'(lsu_ready), 32'(!rst && starve < SMAX));
            chk("reg_wr_en", 32'(reg_wr_en), 32'(m_en));
            chk("rd_addr", 32'(rd_addr), 32'(m_rd));
            chk("w_data", w_data, m_data);
            chk("rs1_busy", 32'(rs1_busy), 32'(mbusy(rs1_addr)));
            chk("rs2_busy", 32'(rs2_busy), 32'(mbusy(rs2_addr)));
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int k, j;
    initial begin
        tick; tick;
        chk("rst_en", 32'(reg_wr_en), 0);
        chk("rst_rd", 32'(rd_addr), 0);
        chk("rst_data", w_data, 0);
        chk("rst_alu_ready", 32'(alu_ready), 0);
        chk("rst_lsu_ready", 32'(lsu_ready), 0);
        rst = 0;
        // ALU bypass
        alu_valid = 1; alu_rd = 5; alu_data = 32'hDEADBEEF;
        tick;
        alu_valid = 0;
        chk("byp_en", 32'(reg_wr_en), 1);
        chk("byp_rd", 32'(rd_addr), 5);
        chk("byp_data", w_data, 32'hDEADBEEF);
        tick;
        chk("byp_idle", 32'(reg_wr_en), 0);
        // LSU/ALU collision
        lsu_valid = 1; lsu_rd = 3; lsu_data = 32'h11;
        alu_valid = 1; alu_rd = 4; alu_data = 32'h22; rs1_addr = 4;
        tick;
        lsu_valid = 0; alu_valid = 0;
        #1;
        chk("col_rd1", 32'(rd_addr), 3);
        chk("col_data1", w_data, 32'h11);
        chk("col_busy_q", 32'(rs1_busy), 1);
        tick;
        chk("col_rd2", 32'(rd_addr), 4);
        chk("col_data2", w_data, 32'h22);
        chk("col_busy_clr", 32'(rs1_busy), 0);
        tick;
        // Full queue and LSU starvation hold-off
        k = 0; j = 0;
        for (int c = 0; c < 8; c++) begin
            lsu_valid = 1; lsu_rd = 5'(10 + k); lsu_data = 32'h1000 + 32'(k);
            alu_valid = j < 4; alu_rd = 5'(20 + j); alu_data = 32'h2000 + 32'(j);
            if (c == 4) begin #1; chk("full_alu_ready", 32'(alu_ready), 0); end
            if (c == 5) begin #1; chk("hold_lsu_ready", 32'(lsu_ready), 0); end
            tick;
            if (c == 5) chk("hold_head_rd", 32'(rd_addr), 20);
            if (m_lf) k++;
            if (m_af) j++;
        end
        lsu_valid = 0; alu_valid = 0;
        repeat (5) tick;
        chk("drain_last_rd", 32'(rd_addr), 23);
        // Scoreboard
        rs2_addr = 7; issue_load = 1; issue_rd = 7;
        tick;
        issue_load = 0; #1;
        chk("sb_set", 32'(rs2_busy), 1);
        lsu_valid = 1; lsu_rd = 7; lsu_data = 32'h77;
        tick;
        lsu_valid = 0; #1;
        chk("sb_clr", 32'(rs2_busy), 0);
        chk("sb_rd", 32'(rd_addr), 7);
        issue_load = 1;
        tick;
        lsu_valid = 1; lsu_data = 32'h78;
        tick;
        lsu_valid = 0; issue_load = 0; #1;
        chk("sb_set_wins", 32'(rs2_busy), 1);
        lsu_valid = 1; lsu_data = 32'h79;
        tick;
        lsu_valid = 0; #1;
        chk("sb_clr2", 32'(rs2_busy), 0);
        // x0 handling
        alu_valid = 1; alu_rd = 0; alu_data = 32'hFFFFFFFF;
        tick;
        alu_valid = 0;
        chk("x0_en", 32'(reg_wr_en), 0);
        chk("x0_rd_hold", 32'(rd_addr), 7);
        chk("x0_data_hold", w_data, 32'h79);
        rs1_addr = 0; issue_load = 1; issue_rd = 0;
        tick;
        issue_load = 0; #1;
        chk("x0_busy", 32'(rs1_busy), 0);
        // Reset mid-operation
        issue_load = 1; issue_rd = 9;
        for (int c = 0; c < 3; c++) begin
            lsu_valid = 1; lsu_rd = 5'(11 + c); lsu_data = 32'h3000 + 32'(c);
            alu_valid = 1; alu_rd = 5'(25 + c); alu_data = 32'h4000 + 32'(c);
            tick;
            issue_load = 0;
        end
        lsu_valid = 0; alu_valid = 0; rs1_addr = 9; rs2_addr = 25; #1;
        chk("pre_rst_busy9", 32'(rs1_busy), 1);
        chk("pre_rst_busyq", 32'(rs2_busy), 1);
        rst = 1; #1;
        chk("in_rst_alu_ready", 32'(alu_ready), 0);
        tick;
        rst = 0; #1;
        chk("post_rst_en", 32'(reg_wr_en), 0);
        chk("post_rst_rd", 32'(rd_addr), 0);
        chk("post_rst_data", w_data, 0);
        chk("post_rst_rs1", 32'(rs1_busy), 0);
        chk("post_rst_rs2", 32'(rs2_busy), 0);
        chk("post_rst_alu_ready", 32'(alu_ready), 1);
        for (int c = 0; c < 4; c++) begin
            tick;
            chk("post_rst_nowrite", 32'(reg_wr_en), 0);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
